cpx_accumulate_dump: RTL and testbench

//  Complex accumulate-and-dump stage, directly downstream of cpx_multiply in the CAF datapath.
//  - Consumes the i_out/q_out product stream and sums LENGTH consecutive accepted products.
//  - Emits one complex sum per block: the correlation value for one CAF lag/frequency bin.
//  - Uses the same valid/ready handshake naming as cpx_multiply, so the two blocks chain directly.

---
 rtl/cpx_acc_pkg.sv | 32 +++
 rtl/cpx_acc_narrow.sv | 43 ++++
 rtl/cpx_accumulate_dump.sv | 107 ++++++++++
 tb/tb_cpx_accumulate_dump.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpx_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpx_acc_pkg
// Brief    : Width helpers and saturation bounds for cpx_accumulate_dump.
// Revision : 1.0
// ============================================================================
package cpx_acc_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Accumulator width that can hold LENGTH worst-case samples without overflow.
  function automatic int acc_bits(input int i_bits, input int q_bits, input int length);
    return ((i_bits > q_bits) ? i_bits : q_bits) + clog2(length);
  endfunction

  function automatic logic signed [63:0] sat_max(input int out_bits);
    return (64'sd1 <<< (out_bits - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int out_bits);
    return -(64'sd1 <<< (out_bits - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpx_acc_narrow.sv
`default_nettype none
// ============================================================================
// Module   : cpx_acc_narrow
// Brief    : Fits a signed accumulator value into the output width. Sign-extends
//            when widening; when narrowing, wraps by default or clamps when
//            CPX_ACCUMULATE_SATURATE_EN is defined.
// Revision : 1.0
// ============================================================================
module cpx_acc_narrow
  import cpx_acc_pkg::*;
#(
  parameter int IN_BITS  = 22,
  parameter int OUT_BITS = 22
) (
  input  logic signed [IN_BITS-1:0]  i_data,
  output logic signed [OUT_BITS-1:0] o_data
);

  generate
    if (OUT_BITS >= IN_BITS) begin : g_widen
      assign o_data = OUT_BITS'(i_data);
    end else begin : g_narrow
`ifdef CPX_ACCUMULATE_SATURATE_EN
      localparam logic signed [IN_BITS-1:0] c_MAX = IN_BITS'(sat_max(OUT_BITS));
      localparam logic signed [IN_BITS-1:0] c_MIN = IN_BITS'(sat_min(OUT_BITS));

      always_comb begin
        o_data = OUT_BITS'(i_data);
        if (i_data > c_MAX) begin
          o_data = OUT_BITS'(c_MAX);
        end else if (i_data < c_MIN) begin
          o_data = OUT_BITS'(c_MIN);
        end
      end
`else
      // Keep the LSB-aligned low bits: plain two's-complement wrap.
      assign o_data = OUT_BITS'(i_data);
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cpx_accumulate_dump.sv
`default_nettype none
// ============================================================================
// Module   : cpx_accumulate_dump
// Brief    : Sums LENGTH accepted complex products and emits one block sum per
//            dump over a valid/ready handshake. Output narrowing saturates when
//            CPX_ACCUMULATE_SATURATE_EN is defined, otherwise wraps.
// Revision : 1.0
// ============================================================================
module cpx_accumulate_dump
  import cpx_acc_pkg::*;
#(
  parameter int I_BITS   = 16,
  parameter int Q_BITS   = 16,
  parameter int LENGTH   = 64,
  parameter int OUT_BITS = acc_bits(I_BITS, Q_BITS, LENGTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [I_BITS-1:0]   i_in,
  input  logic signed [Q_BITS-1:0]   q_in,
  input  logic                       m_axis_tvalid,
  output logic                       s_axis_tready,
  output logic signed [OUT_BITS-1:0] i_sum,
  output logic signed [OUT_BITS-1:0] q_sum,
  output logic                       s_axis_tvalid,
  input  logic                       m_axis_tready
);

  localparam int c_ACC_BITS = acc_bits(I_BITS, Q_BITS, LENGTH);
  localparam int c_CNT_BITS = clog2(LENGTH);
  localparam logic [c_CNT_BITS-1:0] c_LAST = c_CNT_BITS'(LENGTH - 1);

  logic [c_CNT_BITS-1:0]        r_count;
  logic signed [c_ACC_BITS-1:0] r_acc_i;
  logic signed [c_ACC_BITS-1:0] r_acc_q;
  logic signed [OUT_BITS-1:0]   r_i_sum;
  logic signed [OUT_BITS-1:0]   r_q_sum;
  logic                         r_tvalid;

  logic signed [c_ACC_BITS-1:0] w_i_ext;
  logic signed [c_ACC_BITS-1:0] w_q_ext;
  logic signed [c_ACC_BITS-1:0] w_i_full;
  logic signed [c_ACC_BITS-1:0] w_q_full;
  logic signed [OUT_BITS-1:0]   w_i_fit;
  logic signed [OUT_BITS-1:0]   w_q_fit;
  logic                         w_last;
  logic                         w_accept;

  assign w_i_ext  = c_ACC_BITS'(i_in);
  assign w_q_ext  = c_ACC_BITS'(q_in);
  assign w_last   = (r_count == c_LAST);

  // The first sample of a block loads directly, so no separate clear is needed.
  assign w_i_full = (r_count == '0) ? w_i_ext : (r_acc_i + w_i_ext);
  assign w_q_full = (r_count == '0) ? w_q_ext : (r_acc_q + w_q_ext);

  // Only the dumping sample stalls, and only while the old result is still unconsumed.
  assign s_axis_tready = !(w_last && r_tvalid && !m_axis_tready);
  assign w_accept      = m_axis_tvalid && s_axis_tready;

  cpx_acc_narrow #(
    .IN_BITS  (c_ACC_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_narrow_i (
    .i_data (w_i_full),
    .o_data (w_i_fit)
  );

  cpx_acc_narrow #(
    .IN_BITS  (c_ACC_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_narrow_q (
    .i_data (w_q_full),
    .o_data (w_q_fit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_acc_i  <= '0;
      r_acc_q  <= '0;
      r_i_sum  <= '0;
      r_q_sum  <= '0;
      r_tvalid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc_i <= w_i_full;
        r_acc_q <= w_q_full;
        r_count <= w_last ? '0 : (r_count + c_CNT_BITS'(1));
      end
      // A new dump takes priority over a consume in the same cycle, so no bubble.
      if (w_accept && w_last) begin
        r_i_sum  <= w_i_fit;
        r_q_sum  <= w_q_fit;
        r_tvalid <= 1'b1;
      end else if (r_tvalid && m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign i_sum         = r_i_sum;
  assign q_sum         = r_q_sum;
  assign s_axis_tvalid = r_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_cpx_accumulate_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpx_accumulate_dump
// Brief    : Self-checking bench: directed cases plus randomized traffic against
//            a block-sum reference model. Group 0 uses LENGTH=4; group 1 drives
//            two LENGTH=64 instances (OUT_BITS 22 and 18) with shared inputs.
// Revision : 1.0
// ============================================================================
module tb_cpx_accumulate_dump;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic signed [15:0] a_i_in, a_q_in, b_i_in, b_q_in;
  logic               a_vld, a_rdy, a_trdy, a_tv;
  logic signed [17:0] a_i_sum, a_q_sum;
  logic               b_vld, b_trdy;
  logic               b22_rdy, b22_tv, b18_rdy, b18_tv;
  logic signed [21:0] b22_i, b22_q;
  logic signed [17:0] b18_i, b18_q;

  cpx_accumulate_dump #(.LENGTH(4)) dut_a (
    .clk(clk), .reset(reset), .i_in(a_i_in), .q_in(a_q_in),
    .m_axis_tvalid(a_vld), .s_axis_tready(a_rdy),
    .i_sum(a_i_sum), .q_sum(a_q_sum),
    .s_axis_tvalid(a_tv), .m_axis_tready(a_trdy)
  );

  cpx_accumulate_dump dut_b22 (
    .clk(clk), .reset(reset), .i_in(b_i_in), .q_in(b_q_in),
    .m_axis_tvalid(b_vld), .s_axis_tready(b22_rdy),
    .i_sum(b22_i), .q_sum(b22_q),
    .s_axis_tvalid(b22_tv), .m_axis_tready(b_trdy)
  );

  cpx_accumulate_dump #(.LENGTH(64), .OUT_BITS(18)) dut_b18 (
    .clk(clk), .reset(reset), .i_in(b_i_in), .q_in(b_q_in),
    .m_axis_tvalid(b_vld), .s_axis_tready(b18_rdy),
    .i_sum(b18_i), .q_sum(b18_q),
    .s_axis_tvalid(b18_tv), .m_axis_tready(b_trdy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus controls, per group
  bit     rst;
  bit     vld [2];
  bit     trdy[2];
  longint si  [2];
  longint sq  [2];
  bit     last_acc[2];

  // Reference model: samples of the current block, and the presented result
  int     len [2] = '{4, 64};
  longint blk_i[2][64];
  longint blk_q[2][64];
  int     nfill[2];
  bit     ov [2];
  longint oi [2];
  longint oq [2];

  function automatic longint fit(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
`ifdef CPX_ACCUMULATE_SATURATE_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    if (hi < lo) return 0;
    return (v <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

  task automatic step();
    bit rdy[2];
    bit acc[2];
    reset  = rst;
    a_vld  = vld[0];  a_trdy = trdy[0];
    a_i_in = 16'(si[0]); a_q_in = 16'(sq[0]);
    b_vld  = vld[1];  b_trdy = trdy[1];
    b_i_in = 16'(si[1]); b_q_in = 16'(sq[1]);
    #1;
    for (int g = 0; g < 2; g++) begin
      rdy[g] = !(nfill[g] == len[g] - 1 && ov[g] && !trdy[g]);
      acc[g] = !rst && vld[g] && rdy[g];
      last_acc[g] = acc[g];
    end
    if (!rst) begin
      check("a_ready", a_rdy, rdy[0]);
      check("b22_ready", b22_rdy, rdy[1]);
      check("b18_ready", b18_rdy, rdy[1]);
    end
    @(posedge clk);
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        nfill[g] = 0; ov[g] = 0; oi[g] = 0; oq[g] = 0;
      end else begin
        if (ov[g] && trdy[g]) ov[g] = 0;
        if (acc[g]) begin
          blk_i[g][nfill[g]] = si[g];
          blk_q[g][nfill[g]] = sq[g];
          nfill[g]++;
          if (nfill[g] == len[g]) begin
            oi[g] = 0; oq[g] = 0;
            for (int k = 0; k < len[g]; k++) begin
              oi[g] += blk_i[g][k];
              oq[g] += blk_q[g][k];
            end
            ov[g] = 1;
            nfill[g] = 0;
          end
        end
      end
    end
    @(negedge clk);
    check("a_tvalid", a_tv, ov[0]);
    check("a_i_sum", a_i_sum, fit(oi[0], 18));
    check("a_q_sum", a_q_sum, fit(oq[0], 18));
    check("b22_tvalid", b22_tv, ov[1]);
    check("b22_i_sum", b22_i, fit(oi[1], 22));
    check("b22_q_sum", b22_q, fit(oq[1], 22));
    check("b18_tvalid", b18_tv, ov[1]);
    check("b18_i_sum", b18_i, fit(oi[1], 18));
    check("b18_q_sum", b18_q, fit(oq[1], 18));
  endtask

  task automatic send(input int g, input longint i, input longint q);
    int n;
    n = 0;
    vld[g] = 1; si[g] = i; sq[g] = q;
    do begin
      step();
      n++;
    end while (!last_acc[g] && n < 50);
    if (!last_acc[g]) check("send_timeout", 0, 1);
    vld[g] = 0;
  endtask

  initial begin
    rst = 1;
    for (int g = 0; g < 2; g++) begin
      vld[g] = 0; trdy[g] = 1; si[g] = 0; sq[g] = 0;
      nfill[g] = 0; ov[g] = 0; oi[g] = 0; oq[g] = 0;
    end
    @(negedge clk);
    step();
    step();
    check("rst_a_tvalid", a_tv, 0);
    check("rst_a_i_sum", a_i_sum, 0);
    rst = 0;
    step();

    // Contiguous block of (1,-1)
    repeat (4) send(0, 1, -1);
    check("t1_tvalid", a_tv, 1);
    check("t1_i", a_i_sum, 4);
    check("t1_q", a_q_sum, -4);
    step();
    check("t1_one_cycle", a_tv, 0);

    // Backpressure: first result held while next block fills
    trdy[0] = 0;
    for (int k = 1; k <= 7; k++) send(0, k, 0);
    check("t2_held_i", a_i_sum, 10);
    check("t2_held_tv", a_tv, 1);
    vld[0] = 1; si[0] = 8; sq[0] = 0;
    step();
    check("t2_stall", a_rdy, 0);
    trdy[0] = 1;
    send(0, 8, 0);
    check("t2_second_i", a_i_sum, 26);
    check("t2_second_tv", a_tv, 1);
    step();
    check("t2_drained", a_tv, 0);

    // Input gaps between samples
    for (int k = 0; k < 4; k++) begin
      repeat (k) step();
      send(0, 2, 3);
    end
    check("t3_i", a_i_sum, 8);
    check("t3_q", a_q_sum, 12);
    step();

    // Full-scale block at default widths, then narrowing
    repeat (64) send(1, -32768, 32767);
    check("t4_i", b22_i, -2097152);
    check("t4_q", b22_q, 2097088);
    repeat (64) send(1, 32767, -32768);
`ifdef CPX_ACCUMULATE_SATURATE_EN
    check("t5_i", b18_i, 131071);
    check("t5_q", b18_q, -131072);
`else
    check("t5_i", b18_i, -64);
    check("t5_q", b18_q, 0);
`endif
    step();

    // Reset mid-block discards the partial sum
    repeat (2) send(0, 5, 5);
    rst = 1;
    step();
    check("t6_rst_tv", a_tv, 0);
    rst = 0;
    repeat (4) send(0, 1, 1);
    check("t6_i", a_i_sum, 4);
    check("t6_q", a_q_sum, 4);
    step();

    // Randomized traffic with backpressure, gaps and occasional reset
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int g = 0; g < 2; g++) begin
        vld[g]  = ($urandom_range(0, 3) != 0);
        trdy[g] = ($urandom_range(0, 2) != 0);
      end
      si[0] = longint'($signed(16'($urandom)));
      sq[0] = longint'($signed(16'($urandom)));
      case ($urandom_range(0, 2))
        0:       si[1] = -32768;
        1:       si[1] = 32767;
        default: si[1] = longint'($signed(16'($urandom)));
      endcase
      case ($urandom_range(0, 2))
        0:       sq[1] = 32767;
        1:       sq[1] = -32768;
        default: sq[1] = longint'($signed(16'($urandom)));
      endcase
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
